y86_instr_encoder: RTL and testbench
====================================

# y86_instr_encoder

Byte-serial Y86-64 instruction encoder: the writer end of the instruction-memory interface that `fetch` reads. Accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake, builds the canonical 1/2/9/10-byte encoding (little-endian valC) and writes it into the byte-wide instruction memory, one byte per cycle, at an auto-incrementing address. Used to load programs into the SEQ processor's instruction memory before execution starts, and to produce instruction streams for bench stimulus.

## Interface
- `MEM_BYTES`, 1024: instruction memory size in bytes; writes at or beyond this address are never issued.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `addr_load`  in  1  load write pointer from `addr_in`
- `addr_in`  in  64  new write pointer
- `in_valid`  in  1  instruction fields valid
- `in_ready`  out  1  encoder can accept
- `icode`, `ifun`, `rA`, `rB`  in  4 each  instruction fields
- `valC`  in  64  constant or displacement
- `wr_en`  out  1  memory byte write strobe
- `wr_addr`  out  64  byte address
- `wr_data`  out  8  byte value
- `next_addr`  out  64  write pointer, equal to the PC of the next instruction to be written (valP of the last one)
- `instr_err`  out  1  one-cycle pulse: instruction rejected as invalid
- `mem_err`  out  1  sticky: instruction rejected, would cross `MEM_BYTES`

## Operation
- States: IDLE, EMIT.
- IDLE: `in_ready`=1 unless `addr_load`=1. `addr_load` sets `next_addr`=`addr_in`, clears `mem_err`, and takes priority over `in_valid` in the same cycle.
- Accept (`in_valid` & `in_ready`): look up length: icode 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C–F -> invalid.
  - invalid: `instr_err` pulse next cycle, no write, stay IDLE.
  - `next_addr`+len > `MEM_BYTES`: set `mem_err`, no write, stay IDLE.
  - otherwise latch byte buffer {icode:ifun, rA:rB, valC[7:0] … valC[63:0]} (register byte present only for len 2 and 10; valC starts at byte 1 for len 9) and go to EMIT.
- EMIT: each cycle `wr_en`=1, `wr_data`=current byte, `wr_addr`=`next_addr`; `next_addr` increments by 1. Return to IDLE after the last byte. `addr_load` and `in_valid` are ignored in EMIT.
- Address arithmetic is 64-bit unsigned; the bound check is performed before any byte is written, so no wrap-around is ever emitted.

## Timing
- Reset values: state IDLE, `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `next_addr`=0, `instr_err`=0, `mem_err`=0.
- Accept at cycle N -> bytes written at cycles N+1 … N+len; `in_ready`=1 again at N+len+1. Throughput: one instruction per len+1 cycles.
- Rejects: `instr_err`/`mem_err` are visible at N+1; `in_ready` stays 1.
- `rst` mid-EMIT aborts the instruction: `wr_en`=0 and `next_addr`=0 from the next cycle. Bytes already written remain in memory.

## Configuration
- `Y86_IENC_CANON_EN` defined: the instruction is canonicalised and checked. ifun is forced to 0 for icodes other than 2, 6 and 7. rA is forced to F for irmovq. rB is forced to F for pushq and popq. An instruction is rejected via `instr_err` if ifun > 6 for icode 2 or 7, or if ifun > 3 for icode 6.
- Undefined: fields are written exactly as supplied, and only icode validity is checked.

## Structure
- `y86_pkg`: icode constants (`I_HALT` … `I_POPQ`), `RNONE`=4'hF, ALU/condition function codes, and the length function, shared with `fetch`.
- One sub-module: `y86_ilen`, combinational icode/ifun -> {length, valid}, reusable by `fetch` for its valP computation.

## Test plan
- `next_addr`=0, irmovq icode 3, rA F, rB 3, valC 0x0123456789ABCDEF -> 10 writes at addresses 0..9: 30 F3 EF CD AB 89 67 45 23 01; `next_addr`=10.
- halt, nop, ret back-to-back from address 10 -> 00@10, 10@11, 90@12; each accept followed by exactly one `wr_en` cycle.
- jne (icode 7, ifun 4), valC 0x40 -> 9 bytes: 74 40 00 00 00 00 00 00 00; `next_addr` advances by 9.
- icode C -> `instr_err` for 1 cycle, no `wr_en`, `next_addr` unchanged. With `Y86_IENC_CANON_EN` defined, OPq ifun 5 -> same response; without it, bytes 65 rA:rB are written.
- `addr_load` with `addr_in`=`MEM_BYTES`-5, then rmmovq -> `mem_err`=1 and no write. A second `addr_load` clears `mem_err`.
- `rst` after 3 bytes of a 10-byte instruction -> `wr_en`=0 on the next cycle, `next_addr`=0, `in_ready`=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and the icode -> instruction length table,
// used by both the instruction encoder and fetch.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_t;

    // Encoded length in bytes; 0 marks an undefined icode.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:               return 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   return 4'd2;
            I_JXX, I_CALL:                      return 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       return 4'd10;
            default:                            return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/y86_ilen.sv
// Combinational icode/ifun -> {length, valid}. With Y86_IENC_CANON_EN defined,
// out-of-range function codes for rrmovq/cmovXX, jXX and OPq are also rejected.
module y86_ilen (
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic [3:0] len,
    output logic       valid
);
    import y86_pkg::*;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        len   = instr_len(icode);
        valid = (len != 4'd0);
`ifdef Y86_IENC_CANON_EN
        if ((icode == I_RRMOVQ || icode == I_JXX) && ifun > C_G)
            valid = 1'b0;
        if (icode == I_OPQ && ifun > ALU_XOR)
            valid = 1'b0;
`endif
    end

`ifndef Y86_IENC_CANON_EN
    logic unused_ifun;
    assign unused_ifun = ^ifun;
`endif

endmodule

// File: rtl/y86_instr_encoder.sv
// Byte-serial Y86-64 instruction encoder writing into a byte-wide instruction memory.
// Optional field canonicalisation/checking is enabled with Y86_IENC_CANON_EN.
module y86_instr_encoder #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        addr_load,
    input  logic [63:0] addr_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [63:0] next_addr,
    output logic        instr_err,
    output logic        mem_err
);
    import y86_pkg::*;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    enc_state_t  state;
    logic [3:0]  remaining;
    logic [71:0] shift_buf;

    logic [3:0]  len;
    logic        len_valid;
    logic [3:0]  ifun_c, ra_c, rb_c;
    logic [79:0] frame;
    logic        over;
    logic        accept;

    y86_ilen u_ilen (
        .icode (icode),
        .ifun  (ifun),
        .len   (len),
        .valid (len_valid)
    );

    always_comb begin
        ifun_c = ifun;
        ra_c   = rA;
        rb_c   = rB;
`ifdef Y86_IENC_CANON_EN
        if (!(icode == I_RRMOVQ || icode == I_OPQ || icode == I_JXX))
            ifun_c = 4'h0;
        if (icode == I_IRMOVQ)
            ra_c = RNONE;
        if (icode == I_PUSHQ || icode == I_POPQ)
            rb_c = RNONE;
`endif
    end

    // Byte 0 always leads; the register byte exists only for 2- and 10-byte forms.
    always_comb begin
        case (len)
            4'd2:    frame = {64'h0, ra_c, rb_c, icode, ifun_c};
            4'd9:    frame = {8'h0, valC, icode, ifun_c};
            4'd10:   frame = {valC, ra_c, rb_c, icode, ifun_c};
            default: frame = {72'h0, icode, ifun_c};
        endcase
    end

    // Written as a subtraction from the limit so a pointer near 2^64 cannot wrap past the check.
    assign over     = next_addr > (MEM_LIMIT - 64'(len));
    assign in_ready = (state == ENC_IDLE) && !addr_load;
    assign accept   = in_ready && in_valid && len_valid && !over;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENC_IDLE;
            remaining <= 4'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 64'h0;
            wr_data   <= 8'h0;
            next_addr <= 64'h0;
            instr_err <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            instr_err <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    wr_en <= 1'b0;
                    if (addr_load) begin
                        next_addr <= addr_in;
                        mem_err   <= 1'b0;
                    end else if (in_valid) begin
                        if (!len_valid) begin
                            instr_err <= 1'b1;
                        end else if (over) begin
                            mem_err <= 1'b1;
                        end else begin
                            wr_en     <= 1'b1;
                            wr_data   <= frame[7:0];
                            wr_addr   <= next_addr;
                            next_addr <= next_addr + 64'd1;
                            remaining <= len - 4'd1;
                            state     <= ENC_EMIT;
                        end
                    end
                end
                ENC_EMIT: begin
                    if (remaining != 4'd0) begin
                        wr_en     <= 1'b1;
                        wr_data   <= shift_buf[7:0];
                        wr_addr   <= next_addr;
                        next_addr <= next_addr + 64'd1;
                        remaining <= remaining - 4'd1;
                    end else begin
                        wr_en <= 1'b0;
                        state <= ENC_IDLE;
                    end
                end
                default: state <= ENC_IDLE;
            endcase
        end
    end

    // NOTE: the byte buffer is deliberately not reset; it is always loaded on accept before it is read.
    always_ff @(posedge clk) begin
        if (accept)
            shift_buf <= frame[79:8];
        else if (state == ENC_EMIT)
            shift_buf <= {8'h00, shift_buf[71:8]};
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Scoreboard bench for y86_instr_encoder: expected memory writes are queued when an
// instruction is driven and popped by a write monitor. Honours Y86_IENC_CANON_EN.
module tb_y86_instr_encoder;

    localparam int unsigned MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_load;
    logic [63:0] addr_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic [63:0] next_addr;
    logic        instr_err;
    logic        mem_err;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] exp_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    y86_instr_encoder #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .next_addr (next_addr),
        .instr_err (instr_err),
        .mem_err   (mem_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int model_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    task automatic push_byte(input logic [7:0] d);
        wr_t w;
        w.addr = exp_pc;
        w.data = d;
        exp_q.push_back(w);
        exp_pc = exp_pc + 64'd1;
    endtask

    // Write monitor: every strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", {63'h0, wr_en}, 64'h0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", wr_addr, w.addr);
                check("wr_data", {56'h0, wr_data}, {56'h0, w.data});
            end
        end
    end

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready_wait"}, {63'h0, in_ready}, 64'h1);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input string tag);
        int          len;
        bit          fits;
        logic [3:0]  f, a, b;
        logic [63:0] pc0;
        wait_ready(tag);
        f   = fn;
        a   = ra;
        b   = rb;
        len = model_len(ic);
`ifdef Y86_IENC_CANON_EN
        if (!(ic == 4'h2 || ic == 4'h6 || ic == 4'h7)) f = 4'h0;
        if (ic == 4'h3) a = 4'hF;
        if (ic == 4'hA || ic == 4'hB) b = 4'hF;
        if (((ic == 4'h2 || ic == 4'h7) && fn > 4'd6) || (ic == 4'h6 && fn > 4'd3)) len = 0;
`endif
        pc0  = exp_pc;
        fits = (len != 0) && (exp_pc + 64'(len) <= 64'(MEM_BYTES));
        if (fits) begin
            push_byte({ic, f});
            if (len == 2 || len == 10) push_byte({a, b});
            if (len >= 9) for (int i = 0; i < 8; i++) push_byte(vc[8*i +: 8]);
        end
        icode    = ic;
        ifun     = fn;
        rA       = ra;
        rB       = rb;
        valC     = vc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        icode    = 4'($urandom_range(0, 15));
        valC     = {$urandom, $urandom};
        if (len == 0) begin
            check({tag, "_instr_err"}, {63'h0, instr_err}, 64'h1);
            check({tag, "_rej_wr_en"}, {63'h0, wr_en}, 64'h0);
            check({tag, "_rej_ready"}, {63'h0, in_ready}, 64'h1);
            @(negedge clk);
            check({tag, "_instr_err_pulse"}, {63'h0, instr_err}, 64'h0);
            check({tag, "_rej_next_addr"}, next_addr, pc0);
        end else if (!fits) begin
            check({tag, "_mem_err"}, {63'h0, mem_err}, 64'h1);
            check({tag, "_rej_wr_en"}, {63'h0, wr_en}, 64'h0);
            check({tag, "_rej_ready"}, {63'h0, in_ready}, 64'h1);
            @(negedge clk);
            check({tag, "_mem_err_sticky"}, {63'h0, mem_err}, 64'h1);
            check({tag, "_rej_next_addr"}, next_addr, pc0);
        end else begin
            for (int k = 0; k < len; k++) begin
                check({tag, "_emit_wr_en"}, {63'h0, wr_en}, 64'h1);
                check({tag, "_emit_busy"}, {63'h0, in_ready}, 64'h0);
                @(negedge clk);
            end
            check({tag, "_done_wr_en"}, {63'h0, wr_en}, 64'h0);
            check({tag, "_done_ready"}, {63'h0, in_ready}, 64'h1);
            check({tag, "_next_addr"}, next_addr, exp_pc);
        end
    endtask

    // addr_load is presented together with a valid nop to exercise its priority.
    task automatic load_addr(input logic [63:0] a, input string tag);
        addr_load = 1'b1;
        addr_in   = a;
        in_valid  = 1'b1;
        icode     = 4'h1;
        ifun      = 4'h0;
        #1;
        check({tag, "_ready_low"}, {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        addr_load = 1'b0;
        in_valid  = 1'b0;
        exp_pc    = a;
        check({tag, "_next_addr"}, next_addr, a);
        check({tag, "_mem_err_clr"}, {63'h0, mem_err}, 64'h0);
        check({tag, "_no_write"}, {63'h0, wr_en}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        addr_load = 1'b0;
        addr_in   = 64'h0;
        in_valid  = 1'b0;
        icode     = 4'h0;
        ifun      = 4'h0;
        rA        = 4'h0;
        rB        = 4'h0;
        valC      = 64'h0;
        exp_pc    = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_wr_en", {63'h0, wr_en}, 64'h0);
        check("rst_wr_addr", wr_addr, 64'h0);
        check("rst_wr_data", {56'h0, wr_data}, 64'h0);
        check("rst_next_addr", next_addr, 64'h0);
        check("rst_instr_err", {63'h0, instr_err}, 64'h0);
        check("rst_mem_err", {63'h0, mem_err}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, "irmovq");
        check("irmovq_pc10", next_addr, 64'd10);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, "halt");
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, "nop");
        send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0, "ret");
        check("ret_pc13", next_addr, 64'd13);
        send(4'h7, 4'h4, 4'h0, 4'h0, 64'h40, "jne");
        check("jne_pc22", next_addr, 64'd22);
        send(4'hC, 4'h0, 4'h1, 4'h2, 64'h0, "icode_c");
        send(4'hF, 4'h3, 4'h1, 4'h2, 64'h0, "icode_f");
        send(4'h6, 4'h5, 4'h1, 4'h2, 64'h0, "opq_f5");
        send(4'h6, 4'h0, 4'h3, 4'h4, 64'h0, "addq");
        send(4'h2, 4'h1, 4'h5, 4'h6, 64'h0, "cmovle");
        send(4'h4, 4'h0, 4'h2, 4'h5, 64'hFFFF_0000_1234_5678, "rmmovq");
        send(4'h5, 4'h0, 4'h7, 4'h4, 64'h8, "mrmovq");
        send(4'h8, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0000_0100, "call");
        send(4'hA, 4'h0, 4'h3, 4'hF, 64'h0, "pushq");
        send(4'hB, 4'h0, 4'h3, 4'hF, 64'h0, "popq");

        load_addr(64'(MEM_BYTES - 5), "load_1019");
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10, "rmmovq_over");
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, "halt_after_err");
        check("mem_err_held", {63'h0, mem_err}, 64'h1);
        load_addr(64'(MEM_BYTES - 10), "load_1014");
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'hA5A5_5A5A_0F0F_F0F0, "rmmovq_exact_fit");
        check("exact_fit_pc", next_addr, 64'(MEM_BYTES));
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, "halt_at_end");
        load_addr(64'd100, "load_100");

        // Abort a 10-byte rmmovq after three bytes have been written.
        wait_ready("abort");
        push_byte(8'h40);
        push_byte(8'h12);
        push_byte(8'h88);
        icode    = 4'h4;
        ifun     = 4'h0;
        rA       = 4'h1;
        rB       = 4'h2;
        valC     = 64'h1122_3344_5566_7788;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_wr_en", {63'h0, wr_en}, 64'h1);
            if (k < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 64'h0;
        check("abort_wr_en_low", {63'h0, wr_en}, 64'h0);
        check("abort_next_addr", next_addr, 64'h0);
        check("abort_ready", {63'h0, in_ready}, 64'h1);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, "halt_after_abort");

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
